// File: rtl/ps2_keycode.sv
// PS/2 keyboard receiver and Set 2 -> HID keycode decoder.
// Turns raw PS/2 clock/data into validated scan-code bytes, then tracks the
// single currently held movement/control key as a HID usage code.
// Optional macro PS2_KEYCODE_ARROW_MAP_EN: when defined, the extended arrow
// keys report the W/A/S/D movement codes instead of the standard HID arrow
// codes.
module ps2_keycode #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] keycode,
    output logic [7:0] rx_byte,
    output logic       rx_strobe,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizers plus the previous synchronized PS/2 clock for edge detect
    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          clk_prev_q, clk_prev_d;
    logic          data_s1_q, data_s1_d;
    logic          data_s2_q, data_s2_d;

    // Frame receiver state
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_err_q, frame_err_d;

    // Decoder state
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    keycode_q, keycode_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_strobe_q, rx_strobe_d;

    logic          fall_edge;
    logic          byte_ok;
    logic          map_valid;
    logic [7:0]    map_code;

    // Set 2 scan code (with extended flag) to HID usage; valid=0 when unmapped
    function automatic logic [8:0] map_key(input logic ext, input logic [7:0] code);
        logic [8:0] res;
        res = 9'h000;
        case ({ext, code})
            9'h01D: res = {1'b1, 8'h1A};
            9'h01C: res = {1'b1, 8'h04};
            9'h01B: res = {1'b1, 8'h16};
            9'h023: res = {1'b1, 8'h07};
            9'h029: res = {1'b1, 8'h2C};
            9'h05A: res = {1'b1, 8'h28};
`ifdef PS2_KEYCODE_ARROW_MAP_EN
            9'h175: res = {1'b1, 8'h1A};
            9'h16B: res = {1'b1, 8'h04};
            9'h172: res = {1'b1, 8'h16};
            9'h174: res = {1'b1, 8'h07};
`else
            9'h175: res = {1'b1, 8'h52};
            9'h16B: res = {1'b1, 8'h50};
            9'h172: res = {1'b1, 8'h51};
            9'h174: res = {1'b1, 8'h4F};
`endif
            default: res = 9'h000;
        endcase
        return res;
    endfunction

    // Two-flop synchronizer chain and edge-detect history
    always_comb begin
        clk_s1_d   = ps2_clk_in;
        clk_s2_d   = clk_s1_q;
        clk_prev_d = clk_s2_q;
        data_s1_d  = ps2_data_in;
        data_s2_d  = data_s1_q;
    end

    assign fall_edge = clk_prev_q & ~clk_s2_q;

    // Frame FSM: shifts bits on PS/2 falling edges, validates parity/stop, aborts on stall
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        timer_d     = timer_q;
        frame_err_d = 1'b0;
        byte_ok     = 1'b0;

        if (state_q == IDLE || fall_edge) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall_edge && !data_s2_q) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    shift_d   = {data_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    parity_d = data_s2_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_d = IDLE;
                    if ((^{shift_q, parity_q}) && data_s2_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall_edge && timer_q == TIMER_LAST) begin
            state_d     = IDLE;
            timer_d     = '0;
            frame_err_d = 1'b1;
        end
    end

    assign {map_valid, map_code} = map_key(ext_q, shift_q);

    // Byte decoder: prefix flags, make/break tracking of the held key
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        keycode_d   = keycode_q;
        rx_byte_d   = rx_byte_q;
        rx_strobe_d = 1'b0;

        if (byte_ok) begin
            rx_byte_d   = shift_q;
            rx_strobe_d = 1'b1;
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (map_valid) begin
                    if (!brk_q) begin
                        keycode_d = map_code;
                    end else if (map_code == keycode_q) begin
                        keycode_d = 8'h00;
                    end
                end
            end
        end
    end

    // State registers; synchronizers reset to the idle-high bus level
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_s1_q   <= 1'b1;
            data_s2_q   <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_strobe_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_prev_q  <= clk_prev_d;
            data_s1_q   <= data_s1_d;
            data_s2_q   <= data_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            rx_byte_q   <= rx_byte_d;
            rx_strobe_q <= rx_strobe_d;
        end
    end

    assign keycode   = keycode_q;
    assign rx_byte   = rx_byte_q;
    assign rx_strobe = rx_strobe_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode.sv
// Testbench for ps2_keycode: drives PS/2 frames, predicts each strobe or
// error pulse with a small reference model, and compares from a queue.
module tb_ps2_keycode;

   localparam int TIMEOUT = 200;
   localparam int HALF    = 20;

   typedef struct {
      logic       err;
      logic [7:0] rxByte;
      logic [7:0] keyCode;
   } expEntry_t;

   logic       clk;
   logic       rstN;
   logic       ps2Clk;
   logic       ps2Data;
   logic [7:0] keycode;
   logic [7:0] rxByte;
   logic       rxStrobe;
   logic       frameErr;

   int         testCount = 0;
   int         failCount = 0;
   expEntry_t  expQ[$];
   expEntry_t  monEntry;

   logic       mExt;
   logic       mBrk;
   logic [7:0] mKey;
   logic [7:0] mRx;

   ps2_keycode #(.TIMEOUT_CYC(TIMEOUT)) dut (
      .Clk        (clk),
      .Reset_n    (rstN),
      .ps2_clk_in (ps2Clk),
      .ps2_data_in(ps2Data),
      .keycode    (keycode),
      .rx_byte    (rxByte),
      .rx_strobe  (rxStrobe),
      .frame_err  (frameErr)
   );

   // 100 MHz-style free-running system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference mapping of scan codes to HID usages
   task automatic mapKey(input logic ext, input logic [7:0] code, output logic valid, output logic [7:0] hid);
      valid = 1'b1;
      hid   = 8'h00;
      if (!ext) begin
         case (code)
            8'h1D: hid = 8'h1A;
            8'h1C: hid = 8'h04;
            8'h1B: hid = 8'h16;
            8'h23: hid = 8'h07;
            8'h29: hid = 8'h2C;
            8'h5A: hid = 8'h28;
            default: valid = 1'b0;
         endcase
      end else begin
         case (code)
`ifdef PS2_KEYCODE_ARROW_MAP_EN
            8'h75: hid = 8'h1A;
            8'h6B: hid = 8'h04;
            8'h72: hid = 8'h16;
            8'h74: hid = 8'h07;
`else
            8'h75: hid = 8'h52;
            8'h6B: hid = 8'h50;
            8'h72: hid = 8'h51;
            8'h74: hid = 8'h4F;
`endif
            default: valid = 1'b0;
         endcase
      end
   endtask

   // Advance the reference model by one good byte
   task automatic modelByte(input logic [7:0] b);
      logic       valid;
      logic [7:0] hid;
      mRx = b;
      if (b == 8'hE0) begin
         mExt = 1'b1;
      end else if (b == 8'hF0) begin
         mBrk = 1'b1;
      end else begin
         mapKey(mExt, b, valid, hid);
         if (valid) begin
            if (!mBrk) mKey = hid;
            else if (hid == mKey) mKey = 8'h00;
         end
         mExt = 1'b0;
         mBrk = 1'b0;
      end
   endtask

   task automatic modelReset();
      mExt = 1'b0;
      mBrk = 1'b0;
      mKey = 8'h00;
      mRx  = 8'h00;
   endtask

   // Drive the first nBits bits of an 11-bit PS/2 frame, device-side timing
   task automatic sendBits(input logic [7:0] b, input logic badPar, input logic badStop, input int nBits);
      logic [10:0] frame;
      frame = {~badStop, (~^b) ^ badPar, b, 1'b0};
      for (int i = 0; i < nBits; i++) begin
         ps2Data = frame[i];
         repeat (HALF) @(posedge clk);
         ps2Clk = 1'b0;
         repeat (HALF) @(posedge clk);
         ps2Clk = 1'b1;
      end
      ps2Data = 1'b1;
      repeat (3 * HALF) @(posedge clk);
   endtask

   // Push the predicted outcome of one full frame, then transmit it
   task automatic applyStimulus(input logic [7:0] b, input logic badPar, input logic badStop);
      expEntry_t e;
      if (badPar || badStop) begin
         e.err = 1'b1;
      end else begin
         e.err = 1'b0;
         modelByte(b);
      end
      e.rxByte  = mRx;
      e.keyCode = mKey;
      expQ.push_back(e);
      sendBits(b, badPar, badStop, 11);
   endtask

   // Monitor: every strobe or error pulse must match the next predicted entry
   always @(negedge clk) begin
      if (rstN && (rxStrobe || frameErr)) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_pulse", {30'd0, rxStrobe, frameErr}, 32'd0);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("frame_err", {31'd0, frameErr}, {31'd0, monEntry.err});
            checkOutput("rx_strobe", {31'd0, rxStrobe}, {31'd0, ~monEntry.err});
            checkOutput("rx_byte", {24'd0, rxByte}, {24'd0, monEntry.rxByte});
            checkOutput("keycode", {24'd0, keycode}, {24'd0, monEntry.keyCode});
         end
      end
   end

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_keycode"}, {24'd0, keycode}, 32'd0);
      checkOutput({tag, "_rx_byte"}, {24'd0, rxByte}, 32'd0);
      checkOutput({tag, "_rx_strobe"}, {31'd0, rxStrobe}, 32'd0);
      checkOutput({tag, "_frame_err"}, {31'd0, frameErr}, 32'd0);
   endtask

   initial begin
      expEntry_t e;
      logic [7:0] arrowKey;
      int waitCnt;

      ps2Clk  = 1'b1;
      ps2Data = 1'b1;
      rstN    = 1'b0;
      modelReset();
      repeat (5) @(posedge clk);
      #1;
      checkResetState("reset");
      rstN = 1'b1;
      repeat (10) @(posedge clk);

      // Press, repeat, release of W
      applyStimulus(8'h1D, 1'b0, 1'b0);
      checkOutput("press_w", {24'd0, keycode}, 32'h1A);
      applyStimulus(8'h1D, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h1D, 1'b0, 1'b0);
      checkOutput("release_w", {24'd0, keycode}, 32'h00);

      // Last press wins; releasing the older key leaves the new one
      applyStimulus(8'h1D, 1'b0, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h1D, 1'b0, 1'b0);
      checkOutput("last_press_a", {24'd0, keycode}, 32'h04);

      // Corrupted frames: bad parity, then bad stop bit
      applyStimulus(8'h1B, 1'b1, 1'b0);
      applyStimulus(8'h29, 1'b0, 1'b1);
      checkOutput("after_errs", {24'd0, keycode}, 32'h04);

      // Stall after the start bit and 5 data bits
      e.err     = 1'b1;
      e.rxByte  = mRx;
      e.keyCode = mKey;
      expQ.push_back(e);
      sendBits(8'h23, 1'b0, 1'b0, 6);
      repeat (TIMEOUT + 50) @(posedge clk);
      applyStimulus(8'h23, 1'b0, 1'b0);
      checkOutput("after_timeout_d", {24'd0, keycode}, 32'h07);

      // Extended up arrow make and break
`ifdef PS2_KEYCODE_ARROW_MAP_EN
      arrowKey = 8'h1A;
`else
      arrowKey = 8'h52;
`endif
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b0);
      checkOutput("arrow_up", {24'd0, keycode}, {24'd0, arrowKey});
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b0);
      checkOutput("arrow_up_rel", {24'd0, keycode}, 32'h00);

      // Unmapped codes, extended non-arrow, break of a non-held key
      applyStimulus(8'h29, 1'b0, 1'b0);
      applyStimulus(8'h15, 1'b0, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h1D, 1'b0, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b0);
      applyStimulus(8'h5A, 1'b0, 1'b0);
      checkOutput("space_held", {24'd0, keycode}, 32'h2C);
      applyStimulus(8'h5A, 1'b0, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h6B, 1'b0, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h72, 1'b0, 1'b0);
      applyStimulus(8'hE0, 1'b0, 1'b0);
      applyStimulus(8'h74, 1'b0, 1'b0);

      // Reset in the middle of a frame, then a clean frame
      sendBits(8'h1B, 1'b0, 1'b0, 4);
      rstN = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkResetState("midreset");
      rstN = 1'b1;
      repeat (10) @(posedge clk);
      applyStimulus(8'h1D, 1'b0, 1'b0);
      checkOutput("post_reset_w", {24'd0, keycode}, 32'h1A);

      // Drain any outstanding predictions with a bounded wait
      waitCnt = 0;
      while (expQ.size() != 0 && waitCnt < 2000) begin
         @(posedge clk);
         waitCnt++;
      end
      checkOutput("pending", expQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
